// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer driving a shared add/sub ALU.
// Optional MULDIV_EARLY_OUT_EN: skip iterations for zero multiplies and |rs1| < |rs2| divides.
package muldiv_pkg;
    typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_SUB = 2'd1} aluop_t;
endpackage

module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output aluop_t          alu_op,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_carry,
    output logic [1:0]      dbg_state
);
    // Handshake: start is sampled only in IDLE; result is valid in the single
    // cycle done is high and is then held until the next accepted start.
    typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} state_t;

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0]   ONE   = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE2X = {{(2*XLEN-1){1'b0}}, 1'b1};

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_r;
    logic            neg_p, neg_r;
    // Multiply: {hi,lo} is the product/multiplier pair. Divide: hi = remainder, lo = quotient.
    logic [XLEN-1:0] hi, lo, opb;

    logic            is_div, sgn_a, sgn_b, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            is_div_r, div_sub;
    logic [XLEN-1:0] div_t, fix_result;
    logic [2*XLEN-1:0] prod_s;

    assign is_div = op[2];
    assign sgn_a  = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    assign sgn_b  = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    assign a_neg  = sgn_a && rs1[XLEN-1];
    assign b_neg  = sgn_b && rs2[XLEN-1];
    assign mag_a  = a_neg ? (~rs1 + ONE) : rs1;
    assign mag_b  = b_neg ? (~rs2 + ONE) : rs2;

    assign is_div_r = op_r[2];
    assign div_t    = {hi[XLEN-2:0], lo[XLEN-1]};
    // The bit shifted out of hi is the remainder's hidden MSB; when set, t >= divisor always.
    assign div_sub  = hi[XLEN-1] | alu_carry;

    assign dbg_state = state;

    always_comb begin
        alu_op  = ALU_ADD;
        alu_in1 = '0;
        alu_in2 = '0;
        if (state == ITER) begin
            alu_op  = is_div_r ? ALU_SUB : ALU_ADD;
            alu_in1 = is_div_r ? div_t : hi;
            alu_in2 = opb;
        end
    end

    always_comb begin
        prod_s     = neg_p ? (~{hi, lo} + ONE2X) : {hi, lo};
        fix_result = '0;
        unique case (op_r)
            3'd0:                fix_result = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    fix_result = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:          fix_result = neg_p ? (~lo + ONE) : lo;
            default:             fix_result = neg_r ? (~hi + ONE) : hi;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            cnt    <= '0;
            op_r   <= '0;
            neg_p  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            opb    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_r  <= op;
                        neg_p <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        cnt   <= '0;
                        hi    <= '0;
                        lo    <= is_div ? mag_a : mag_b;
                        opb   <= is_div ? mag_b : mag_a;
                        if (is_div && rs2 == '0) begin
                            // Divide by zero: no iteration and no sign fixup.
                            result <= op[1] ? rs1 : '1;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
`ifdef MULDIV_EARLY_OUT_EN
                        else if (!is_div && (mag_a == '0 || mag_b == '0)) begin
                            lo    <= '0;
                            busy  <= 1'b1;
                            state <= FIXUP;
                        end else if (is_div && mag_a < mag_b) begin
                            hi    <= mag_a;
                            lo    <= '0;
                            busy  <= 1'b1;
                            state <= FIXUP;
                        end
`endif
                        else begin
                            busy  <= 1'b1;
                            state <= ITER;
                        end
                    end
                end
                ITER: begin
                    if (is_div_r) begin
                        hi <= div_sub ? alu_out : div_t;
                        lo <= {lo[XLEN-2:0], div_sub};
                    end else if (lo[0]) begin
                        hi <= {alu_carry, alu_out[XLEN-1:1]};
                        lo <= {alu_out[0], lo[XLEN-1:1]};
                    end else begin
                        hi <= {1'b0, hi[XLEN-1:1]};
                        lo <= {hi[0], lo[XLEN-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(XLEN - 1)) state <= FIXUP;
                end
                FIXUP: begin
                    result <= fix_result;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide instructions.
- Reuses the shared 32-bit ALU (its add/sub path) for every iteration step, instead of adding a dedicated adder array.
- Sits beside the execute stage: issues ALU ops and operands each cycle and consumes the ALU's out/carry.
- Accepts one operation per start pulse; returns a 32-bit result with a one-cycle done pulse.

Parameters:
- XLEN, 32, operand/result width; the ALU and the iteration count equal XLEN.

Ports:
- CLK  input  1  clock, rising edge
- nRST  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1  input  XLEN  operand A (dividend/multiplicand), captured at accept
- rs2  input  XLEN  operand B (divisor/multiplier), captured at accept
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse; result valid
- result  output  XLEN  final result, held until next accept
- alu_op  output  aluop_t  op to shared ALU (ALU_ADD / ALU_SUB only)
- alu_in1  output  XLEN  ALU operand 1
- alu_in2  output  XLEN  ALU operand 2
- alu_out  input  XLEN  ALU result
- alu_carry  input  1  ALU carry; for ALU_SUB carry=1 means no borrow (in1 >= in2 unsigned)

Behaviour:
- Clock and reset: one clock CLK; nRST asynchronous, active-low.
- Reset values: state=IDLE, busy=0, done=0, result=0, alu_op=ALU_ADD, alu_in1=0, alu_in2=0, internal registers 0.
- Reset mid-operation aborts immediately; no done is produced.
- Signedness: operands are converted to magnitudes at accept using internal two's-complement logic.
  - MULH: both operands signed.
  - MULHSU: rs1 signed only.
  - DIV/REM: both signed.
  - Sign flags neg_p and neg_r are stored at accept.
- States: IDLE, ITER, FIXUP, DONE.
- IDLE:
  - busy=0.
  - start=1 → capture magnitudes, cnt=0.
  - Divide op with rs2==0 → DONE directly.
  - Otherwise → ITER.
- ITER (exactly XLEN cycles, cnt 0..XLEN-1), busy=1.
  - MUL step: alu_op=ADD, in1=hi, in2=mcand.
    - If lo[0]: {hi,lo} <= {alu_carry, alu_out, lo[XLEN-1:1]}.
    - Else: {hi,lo} <= {1'b0, hi, lo[XLEN-1:1]}.
  - DIV step (restoring): t={rem[XLEN-2:0], quo[XLEN-1]}; alu_op=SUB, in1=t, in2=divisor.
    - If alu_carry: rem<=alu_out.
    - Else: rem<=t.
    - quo <= {quo[XLEN-2:0], alu_carry}.
    - Divisor magnitude ≥ 2^(XLEN-1) needs a 33rd remainder bit, kept internally: the step subtracts when rem's hidden MSB is set, regardless of carry.
  - cnt==XLEN-1 → FIXUP.
- FIXUP (1 cycle), busy=1:
  - Select the result: MUL → lo; MULH/MULHSU/MULHU → hi; DIV/DIVU → quo; REM/REMU → rem.
  - Negate the 64-bit product when neg_p; negate quo when neg_p (signs differ); negate rem when dividend negative.
  - → DONE.
- DONE (1 cycle): done=1, busy=0, result registered; → IDLE.
- Latency: accept at cycle 0 → done at cycle XLEN+2 (34); next start is accepted the cycle after done.
- Divide by zero:
  - quotient=all ones (0xFFFFFFFF), remainder=rs1.
  - done at cycle 1.
  - No sign fixup applied.
- Overflow DIV 0x80000000 / -1:
  - Falls out naturally: quotient 0x80000000, remainder 0.
  - No special case.
- start while not IDLE: ignored, no queuing.
- start with done=1: ignored, since state is still DONE that cycle.
- Outside ITER, alu_op/alu_in1/alu_in2 return to ADD/0/0.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: at accept, skip ITER and go IDLE→FIXUP (done at cycle 2) when either:
  - a multiply op has either operand magnitude zero; product=0 is loaded;
  - a divide op (rs2≠0) has |rs1| < |rs2| unsigned; quo=0 and rem=|rs1| are loaded.
- Undefined: every non-div-by-zero op takes the full XLEN iterations; latency is fixed at 34.

Test Plan:
- MUL rs1=7, rs2=6 → done at cycle 34, result=0x0000002A; busy high cycles 1..33.
- MULH rs1=0xFFFFFFFF (-1), rs2=0xFFFFFFFF → result=0x00000000; MULHU same operands → 0xFFFFFFFE; MULHSU rs1=-1, rs2=2 → 0xFFFFFFFF.
- DIV rs1=-7 (0xFFFFFFF9), rs2=2 → result=0xFFFFFFFD (-3); REM same → 0xFFFFFFFF (-1); DIVU 0x80000000/-1 → 0; DIV 0x80000000/-1 → 0x80000000; REM same → 0.
- DIVU rs1=0x1234, rs2=0 → done at cycle 1, result=0xFFFFFFFF; REM rs1=0x1234, rs2=0 → 0x00001234.
- start pulsed at cycle 10 of a running MUL → ignored, first result unchanged; nRST low at cycle 15 → busy=0, done never pulses, outputs at reset values.
- With MULDIV_EARLY_OUT_EN: MUL 0×5 → done at cycle 2, result 0; DIVU 3/10 → done at cycle 2, result 0; REMU 3/10 → 3. Without the macro, the same ops take 34 cycles with identical results.
